// File: rtl/snow64_mem_req_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// snow64_mem_req_scheduler_pkg
//
// Purpose: shared widths, FSM state encodings, requester identifiers and the
// partial port structs used by the memory request scheduler and its arbiter.
//
// Contents:
//   AddrWidth / LarDataWidth   - address and LAR data widths
//   MemAccTypRead / Write      - out_mem_access.mem_acc_type encodings
//   StIdle / StWaitMem         - scheduler FSM state encodings
//   Requester                  - requester identifiers (also slot indices)
//   PartialPort*               - packed request/response port structs
//   nextRequester()            - round-robin successor helper
//   sameLine()                 - 32-byte line address comparison
// ---------------------------------------------------------------------------
package snow64_mem_req_scheduler_pkg;

    localparam int AddrWidth     = 64;
    localparam int LarDataWidth  = 256;
    localparam int NumRequesters = 3;

    localparam logic MemAccTypRead  = 1'b0;
    localparam logic MemAccTypWrite = 1'b1;

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StWaitMem = 1'b1;

    // The encoding doubles as the slot index inside the scheduler.
    typedef enum logic [1:0] {
        ReqInstr  = 2'd0,
        ReqRdData = 2'd1,
        ReqWrData = 2'd2
    } Requester;

    typedef struct packed {
        logic                 req;
        logic [AddrWidth-1:0] addr;
    } PartialPortIn_ReqRead;

    typedef struct packed {
        logic                    req;
        logic [AddrWidth-1:0]    addr;
        logic [LarDataWidth-1:0] data;
    } PartialPortIn_ReqWrite;

    typedef struct packed {
        logic                    valid;
        logic [LarDataWidth-1:0] data;
    } PartialPortIn_MemAccess;

    typedef struct packed {
        logic                    valid;
        logic                    cmd_accepted;
        logic [LarDataWidth-1:0] data;
    } PartialPortOut_ReqRead;

    typedef struct packed {
        logic valid;
        logic cmd_accepted;
    } PartialPortOut_ReqWrite;

    typedef struct packed {
        logic                    req;
        logic [AddrWidth-1:0]    addr;
        logic [LarDataWidth-1:0] data;
        logic                    mem_acc_type;
    } PartialPortOut_MemAccess;

    function automatic Requester nextRequester(input Requester r);
        case (r)
            ReqInstr:  return ReqRdData;
            ReqRdData: return ReqWrData;
            default:   return ReqInstr;
        endcase
    endfunction

    // Two addresses hit the same 32-byte LAR line when bits [63:5] agree.
    function automatic logic sameLine(input logic [AddrWidth-1:0] a,
                                      input logic [AddrWidth-1:0] b);
        return a[AddrWidth-1:5] == b[AddrWidth-1:5];
    endfunction

endpackage

// File: rtl/snow64_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// snow64_mem_req_arbiter
//
// Purpose: purely combinational choice of the next slot to grant among the
// eligible slots.
//
// Configuration macro: SNOW64_MEM_REQ_SCHEDULER_ROUND_ROBIN_EN
//   defined   - round-robin in the order read_instr, read_data, write_data,
//               starting the search at ptr_i
//   undefined - fixed priority write_data > read_data > read_instr, and the
//               pointer port does not exist
//
// Ports:
//   eligible_i     in  3  one bit per Requester index, 1 = may be granted
//   ptr_i          in  2  round-robin start point (round-robin build only)
//   grant_valid_o  out 1  at least one slot is eligible
//   grant_o        out 2  chosen requester (ReqInstr when nothing eligible)
// ---------------------------------------------------------------------------
module snow64_mem_req_arbiter
    import snow64_mem_req_scheduler_pkg::*;
(
    input  logic [NumRequesters-1:0] eligible_i,
`ifdef SNOW64_MEM_REQ_SCHEDULER_ROUND_ROBIN_EN
    input  Requester                 ptr_i,
`endif
    output logic                     grant_valid_o,
    output Requester                 grant_o
);

    always_comb begin
        grant_valid_o = |eligible_i;
        grant_o       = ReqInstr;
`ifdef SNOW64_MEM_REQ_SCHEDULER_ROUND_ROBIN_EN
        // Search the eligible vector circularly, beginning at the pointer.
        case (ptr_i)
            ReqRdData: begin
                if      (eligible_i[ReqRdData]) grant_o = ReqRdData;
                else if (eligible_i[ReqWrData]) grant_o = ReqWrData;
                else if (eligible_i[ReqInstr])  grant_o = ReqInstr;
            end
            ReqWrData: begin
                if      (eligible_i[ReqWrData]) grant_o = ReqWrData;
                else if (eligible_i[ReqInstr])  grant_o = ReqInstr;
                else if (eligible_i[ReqRdData]) grant_o = ReqRdData;
            end
            default: begin
                if      (eligible_i[ReqInstr])  grant_o = ReqInstr;
                else if (eligible_i[ReqRdData]) grant_o = ReqRdData;
                else if (eligible_i[ReqWrData]) grant_o = ReqWrData;
            end
        endcase
`else
        if      (eligible_i[ReqWrData]) grant_o = ReqWrData;
        else if (eligible_i[ReqRdData]) grant_o = ReqRdData;
        else if (eligible_i[ReqInstr])  grant_o = ReqInstr;
`endif
    end

endmodule

// File: rtl/snow64_mem_req_scheduler.sv
// ---------------------------------------------------------------------------
// snow64_mem_req_scheduler
//
// Purpose: shares the single external memory port among three requesters
// (instruction read, data read, data write). Each requester owns a one-entry
// slot; one occupied, eligible slot at a time is granted and its memory
// transaction is run to completion before the next grant.
//
// Configuration macro: SNOW64_MEM_REQ_SCHEDULER_ROUND_ROBIN_EN
//   defined   - round-robin arbitration with a pointer register
//   undefined - fixed priority write > read_data > read_instr
//
// Ports:
//   clk                 in   1    rising-edge clock
//   rst_n               in   1    synchronous active-low reset
//   in_req_read_instr   in   65   {req, addr}
//   in_req_read_data    in   65   {req, addr}
//   in_req_write_data   in   321  {req, addr, data}
//   in_mem_access       in   257  {valid, data} memory completion
//   out_req_read_instr  out  258  {valid, cmd_accepted, data}
//   out_req_read_data   out  258  {valid, cmd_accepted, data}
//   out_req_write_data  out  2    {valid, cmd_accepted}
//   out_mem_access      out  322  {req, addr, data, mem_acc_type}
// ---------------------------------------------------------------------------
module snow64_mem_req_scheduler
    import snow64_mem_req_scheduler_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  PartialPortIn_ReqRead    in_req_read_instr,
    input  PartialPortIn_ReqRead    in_req_read_data,
    input  PartialPortIn_ReqWrite   in_req_write_data,
    input  PartialPortIn_MemAccess  in_mem_access,
    output PartialPortOut_ReqRead   out_req_read_instr,
    output PartialPortOut_ReqRead   out_req_read_data,
    output PartialPortOut_ReqWrite  out_req_write_data,
    output PartialPortOut_MemAccess out_mem_access
);

    logic [NumRequesters-1:0] occ_q, occ_d;
    logic [AddrWidth-1:0]     slotAddr_q [NumRequesters];
    logic [AddrWidth-1:0]     slotAddr_d [NumRequesters];
    logic [LarDataWidth-1:0]  wrData_q, wrData_d;
    logic                     rbwInstr_q, rbwInstr_d;
    logic                     rbwData_q, rbwData_d;
    logic [0:0]               state_q, state_d;
    Requester                 grant_q, grant_d;
    logic [LarDataWidth-1:0]  rdData_q, rdData_d;
    logic [NumRequesters-1:0] valid_q, valid_d;
    logic [NumRequesters-1:0] cmdAcc_q;

    logic [NumRequesters-1:0] load;
    logic [NumRequesters-1:0] eligible;
    logic                     memDone;
    logic                     wrStays;
    logic                     hazInstr, hazData;
    logic                     arbValid;
    Requester                 arbGrant;

`ifdef SNOW64_MEM_REQ_SCHEDULER_ROUND_ROBIN_EN
    Requester                 ptr_q, ptr_d;
`endif

    // Slot loading and eligibility. Only the registered occupied bit gates a
    // load, so a slot freeing on this edge still refuses a new request.
    // A read parked behind an older write to the same line must wait for it.
    always_comb begin
        load[ReqInstr]  = in_req_read_instr.req & ~occ_q[ReqInstr];
        load[ReqRdData] = in_req_read_data.req  & ~occ_q[ReqRdData];
        load[ReqWrData] = in_req_write_data.req & ~occ_q[ReqWrData];

        memDone = (state_q == StWaitMem) && in_mem_access.valid;
        wrStays = occ_q[ReqWrData] & ~(memDone && grant_q == ReqWrData);

        hazInstr = rbwInstr_q & occ_q[ReqWrData]
                 & sameLine(slotAddr_q[ReqInstr], slotAddr_q[ReqWrData]);
        hazData  = rbwData_q & occ_q[ReqWrData]
                 & sameLine(slotAddr_q[ReqRdData], slotAddr_q[ReqWrData]);

        eligible = occ_q & ~{1'b0, hazData, hazInstr};
    end

    snow64_mem_req_arbiter u_arbiter (
        .eligible_i    (eligible),
`ifdef SNOW64_MEM_REQ_SCHEDULER_ROUND_ROBIN_EN
        .ptr_i         (ptr_q),
`endif
        .grant_valid_o (arbValid),
        .grant_o       (arbGrant)
    );

    // Next-state logic: completion of the granted transaction, new grants
    // from StIdle, and slot loads. A completing write also clears both
    // read-behind-write flags so a later write cannot block an older read.
    always_comb begin
        occ_d      = occ_q;
        slotAddr_d = slotAddr_q;
        wrData_d   = wrData_q;
        rbwInstr_d = rbwInstr_q;
        rbwData_d  = rbwData_q;
        state_d    = state_q;
        grant_d    = grant_q;
        rdData_d   = rdData_q;
        valid_d    = '0;
`ifdef SNOW64_MEM_REQ_SCHEDULER_ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif

        if (memDone) begin
            occ_d[grant_q]   = 1'b0;
            valid_d[grant_q] = 1'b1;
            state_d          = StIdle;
            case (grant_q)
                ReqInstr: begin
                    rdData_d   = in_mem_access.data;
                    rbwInstr_d = 1'b0;
                end
                ReqRdData: begin
                    rdData_d  = in_mem_access.data;
                    rbwData_d = 1'b0;
                end
                default: begin
                    rbwInstr_d = 1'b0;
                    rbwData_d  = 1'b0;
                end
            endcase
        end else if (state_q == StIdle && arbValid) begin
            state_d = StWaitMem;
            grant_d = arbGrant;
`ifdef SNOW64_MEM_REQ_SCHEDULER_ROUND_ROBIN_EN
            ptr_d   = nextRequester(arbGrant);
`endif
        end

        if (load[ReqInstr]) begin
            occ_d[ReqInstr]      = 1'b1;
            slotAddr_d[ReqInstr] = in_req_read_instr.addr;
            rbwInstr_d           = wrStays | load[ReqWrData];
        end
        if (load[ReqRdData]) begin
            occ_d[ReqRdData]      = 1'b1;
            slotAddr_d[ReqRdData] = in_req_read_data.addr;
            rbwData_d             = wrStays | load[ReqWrData];
        end
        if (load[ReqWrData]) begin
            occ_d[ReqWrData]      = 1'b1;
            slotAddr_d[ReqWrData] = in_req_write_data.addr;
            wrData_d              = in_req_write_data.data;
        end
    end

    // State registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q      <= '0;
            for (int i = 0; i < NumRequesters; i++) begin
                slotAddr_q[i] <= '0;
            end
            wrData_q   <= '0;
            rbwInstr_q <= 1'b0;
            rbwData_q  <= 1'b0;
            state_q    <= StIdle;
            grant_q    <= ReqInstr;
            rdData_q   <= '0;
            valid_q    <= '0;
            cmdAcc_q   <= '0;
`ifdef SNOW64_MEM_REQ_SCHEDULER_ROUND_ROBIN_EN
            ptr_q      <= ReqInstr;
`endif
        end else begin
            occ_q      <= occ_d;
            slotAddr_q <= slotAddr_d;
            wrData_q   <= wrData_d;
            rbwInstr_q <= rbwInstr_d;
            rbwData_q  <= rbwData_d;
            state_q    <= state_d;
            grant_q    <= grant_d;
            rdData_q   <= rdData_d;
            valid_q    <= valid_d;
            cmdAcc_q   <= load;
`ifdef SNOW64_MEM_REQ_SCHEDULER_ROUND_ROBIN_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    // Output decode. Read data is only shown alongside its valid pulse, and
    // the memory bus is all zero whenever no request is being presented.
    always_comb begin
        out_req_read_instr              = '0;
        out_req_read_instr.valid        = valid_q[ReqInstr];
        out_req_read_instr.cmd_accepted = cmdAcc_q[ReqInstr];
        out_req_read_instr.data         = valid_q[ReqInstr] ? rdData_q : '0;

        out_req_read_data               = '0;
        out_req_read_data.valid         = valid_q[ReqRdData];
        out_req_read_data.cmd_accepted  = cmdAcc_q[ReqRdData];
        out_req_read_data.data          = valid_q[ReqRdData] ? rdData_q : '0;

        out_req_write_data              = '0;
        out_req_write_data.valid        = valid_q[ReqWrData];
        out_req_write_data.cmd_accepted = cmdAcc_q[ReqWrData];

        out_mem_access = '0;
        if (state_q == StWaitMem) begin
            out_mem_access.req  = 1'b1;
            out_mem_access.addr = slotAddr_q[grant_q];
            if (grant_q == ReqWrData) begin
                out_mem_access.data         = wrData_q;
                out_mem_access.mem_acc_type = MemAccTypWrite;
            end else begin
                out_mem_access.mem_acc_type = MemAccTypRead;
            end
        end
    end

endmodule

// File: tb/tb_snow64_mem_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_snow64_mem_req_scheduler
//
// Purpose: self-checking bench for snow64_mem_req_scheduler. A scoreboard
// queue holds the expected memory transactions in expected grant order; the
// per-cycle monitor compares the memory bus against the queue head and pops
// it when the owning requester reports valid. A small memory model answers
// requests after a configurable number of cycles.
//
// Configuration macro: SNOW64_MEM_REQ_SCHEDULER_ROUND_ROBIN_EN selects which
// arbitration order is expected.
// ---------------------------------------------------------------------------
module tb_snow64_mem_req_scheduler;
   import snow64_mem_req_scheduler_pkg::*;

`ifdef SNOW64_MEM_REQ_SCHEDULER_ROUND_ROBIN_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   PartialPortIn_ReqRead    reqInstr;
   PartialPortIn_ReqRead    reqData;
   PartialPortIn_ReqWrite   reqWrite;
   PartialPortIn_MemAccess  memIn;
   PartialPortOut_ReqRead   outInstr;
   PartialPortOut_ReqRead   outData;
   PartialPortOut_ReqWrite  outWrite;
   PartialPortOut_MemAccess outMem;

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   snow64_mem_req_scheduler dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .in_req_read_instr  (reqInstr),
      .in_req_read_data   (reqData),
      .in_req_write_data  (reqWrite),
      .in_mem_access      (memIn),
      .out_req_read_instr (outInstr),
      .out_req_read_data  (outData),
      .out_req_write_data (outWrite),
      .out_mem_access     (outMem)
   );

   typedef struct {
      int          who;
      logic [63:0] addr;
      logic [255:0] data;
   } Expect;

   typedef struct {
      int          who;
      logic [63:0] addr;
      logic [255:0] data;
      int          delay;
      int          expLat;
   } Vec;

   Expect expQ[$];
   Vec    vecs[6];

   int passCount   = 0;
   int checkCount  = 0;
   int cycle       = 0;
   int memDelay    = 0;
   int memWait     = 0;
   bit autoRelease = 1'b1;
   int accCount[3];
   logic [2:0] lastValid;
   logic [2:0] lastAccept;

   localparam logic [255:0] WrPattern = {8{32'hDEAD_BEEF}};

   // Memory contents model: the address 0x1000 holds all 0xAA bytes.
   function automatic logic [255:0] memModel(input logic [63:0] addr);
      if (addr == 64'h1000) return {32{8'hAA}};
      return {4{addr ^ 64'h0123_4567_89AB_CDEF}};
   endfunction

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string name, input logic [321:0] actual,
                              input logic [321:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
   endtask

   // Advance to the next falling edge, check the memory bus and requester
   // completions against the scoreboard, then drive the memory model and
   // release any request whose command was accepted.
   task automatic tick();
      Expect e;
      logic [255:0] rdOut;
      @(negedge clk);
      cycle++;
      lastValid  = {outWrite.valid, outData.valid, outInstr.valid};
      lastAccept = {outWrite.cmd_accepted, outData.cmd_accepted, outInstr.cmd_accepted};
      for (int i = 0; i < 3; i++) if (lastAccept[i]) accCount[i]++;

      if (outMem.req) begin
         if (expQ.size() == 0) begin
            checkOutput("memUnexpectedReq", outMem, '0);
         end else begin
            checkOutput("memReq", outMem,
                        {1'b1, expQ[0].addr,
                         (expQ[0].who == 2) ? expQ[0].data : 256'b0,
                         expQ[0].who == 2});
         end
         memWait++;
         if (memWait > memDelay) memIn = {1'b1, memModel(outMem.addr)};
         else memIn = '0;
      end else begin
         checkOutput("memIdleZero", outMem, '0);
         memWait = 0;
         memIn   = '0;
      end

      for (int i = 0; i < 3; i++) begin
         if (lastValid[i]) begin
            if (expQ.size() == 0) begin
               checkOutput("validUnexpected", 322'(lastValid), '0);
            end else begin
               e = expQ.pop_front();
               checkOutput("validWho", i, e.who);
               rdOut = (i == 0) ? outInstr.data : outData.data;
               if (i != 2) checkOutput("readData", rdOut, memModel(e.addr));
            end
         end
      end

      if (autoRelease) begin
         if (lastAccept[0]) reqInstr.req = 1'b0;
         if (lastAccept[1]) reqData.req  = 1'b0;
         if (lastAccept[2]) reqWrite.req = 1'b0;
      end
   endtask

   task automatic applyStimulus(input int who, input logic [63:0] addr,
                                input logic [255:0] data);
      case (who)
         0:       reqInstr = {1'b1, addr};
         1:       reqData  = {1'b1, addr};
         default: reqWrite = {1'b1, addr, data};
      endcase
   endtask

   task automatic pushExp(input int who, input logic [63:0] addr,
                          input logic [255:0] data);
      Expect e;
      e.who  = who;
      e.addr = addr;
      e.data = (who == 2) ? data : 256'b0;
      expQ.push_back(e);
   endtask

   task automatic drain(input int bound);
      for (int n = 0; n < bound && expQ.size() > 0; n++) tick();
      checkOutput("drainDone", expQ.size(), 0);
      expQ.delete();
   endtask

   // One isolated transaction; lat is cycles from driving req to valid.
   task automatic runOne(input int who, input logic [63:0] addr,
                         input logic [255:0] data, input int delay,
                         output int lat);
      int start;
      memDelay = delay;
      applyStimulus(who, addr, data);
      pushExp(who, addr, data);
      start = cycle;
      lat   = -1;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (lastValid[who]) begin
            lat = cycle - start;
            break;
         end
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "Instr"}, outInstr, '0);
      checkOutput({tag, "Data"},  outData,  '0);
      checkOutput({tag, "Write"}, outWrite, '0);
      checkOutput({tag, "Mem"},   outMem,   '0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      logic [63:0] rdAddr;

      vecs[0] = '{0, 64'h0000_0000_0000_0010, '0,                         0, 3};
      vecs[1] = '{1, 64'hFFFF_FFFF_FFFF_FFE0, '0,                         0, 3};
      vecs[2] = '{2, 64'h0000_0000_0000_0040, {4{64'h1122_3344_5566_7788}}, 0, 3};
      vecs[3] = '{1, 64'h1234_5678_0000_0008, '0,                         2, 5};
      vecs[4] = '{2, 64'h0000_0000_0000_00A0, WrPattern,                  1, 4};
      vecs[5] = '{0, 64'h8000_0000_0000_0000, '0,                         4, 7};

      rst_n    = 1'b0;
      reqInstr = '0;
      reqData  = '0;
      reqWrite = '0;
      memIn    = '0;
      for (int i = 0; i < 3; i++) accCount[i] = 0;

      tick();
      tick();
      checkAllZero("reset");
      rst_n = 1'b1;

      // All three requests in one cycle.
      applyStimulus(0, 64'h100, '0);
      applyStimulus(1, 64'h200, '0);
      applyStimulus(2, 64'h300, WrPattern);
      if (RrEn) begin
         pushExp(0, 64'h100, '0);
         pushExp(1, 64'h200, '0);
         pushExp(2, 64'h300, WrPattern);
      end else begin
         pushExp(2, 64'h300, WrPattern);
         pushExp(1, 64'h200, '0);
         pushExp(0, 64'h100, '0);
      end
      tick();
      checkOutput("acceptAll", 322'(lastAccept), 322'(3'b111));
      drain(60);

      // Single instruction read with cycle-exact timing.
      memDelay = 0;
      applyStimulus(0, 64'h1000, '0);
      pushExp(0, 64'h1000, '0);
      tick();
      checkOutput("t1Accept", 322'(outInstr.cmd_accepted), 322'(1));
      checkOutput("t1NoMemYet", 322'(outMem.req), 322'(0));
      tick();
      checkOutput("t1MemReq", outMem, {1'b1, 64'h1000, 256'b0, MemAccTypRead});
      tick();
      checkOutput("t1Valid", outInstr, {1'b1, 1'b0, {32{8'hAA}}});
      drain(10);

      // Table of isolated transactions with varying memory latency.
      for (int i = 0; i < 6; i++) begin
         runOne(vecs[i].who, vecs[i].addr, vecs[i].data, vecs[i].delay, lat);
         checkOutput("vecLatency", lat, vecs[i].expLat);
      end
      drain(10);

      // Read behind a write: same line must wait, different line need not.
      for (int k = 0; k < 2; k++) begin
         rdAddr   = (k == 0) ? 64'h2010 : 64'h3000;
         memDelay = 3;
         applyStimulus(0, 64'h5000, '0);
         pushExp(0, 64'h5000, '0);
         tick();
         tick();
         applyStimulus(2, 64'h2000, WrPattern);
         applyStimulus(1, rdAddr, '0);
         if (k == 0 || !RrEn) begin
            pushExp(2, 64'h2000, WrPattern);
            pushExp(1, rdAddr, '0);
         end else begin
            pushExp(1, rdAddr, '0);
            pushExp(2, 64'h2000, WrPattern);
         end
         drain(60);
      end

      // Request held while the slot is busy.
      memDelay    = 2;
      autoRelease = 1'b0;
      accCount[1] = 0;
      applyStimulus(1, 64'h6000, '0);
      pushExp(1, 64'h6000, '0);
      tick();
      reqData.addr = 64'h7000;
      for (int n = 0; n < 20 && !lastValid[1]; n++) tick();
      checkOutput("heldOneAccept", accCount[1], 1);
      pushExp(1, 64'h7000, '0);
      autoRelease = 1'b1;
      drain(40);
      checkOutput("heldSecondAccept", accCount[1], 2);

      // Reset in the middle of a transaction, then a stale memory valid.
      memDelay = 1000;
      applyStimulus(0, 64'h8000, '0);
      pushExp(0, 64'h8000, '0);
      for (int n = 0; n < 10 && !outMem.req; n++) tick();
      checkOutput("rstMidReqSeen", 322'(outMem.req), 322'(1));
      rst_n = 1'b0;
      reqInstr = '0;
      reqData  = '0;
      reqWrite = '0;
      expQ.delete();
      tick();
      checkAllZero("rstMid");
      rst_n = 1'b1;
      memIn = {1'b1, {8{32'h5555_AAAA}}};
      tick();
      checkAllZero("rstStale");
      tick();
      checkAllZero("rstAfter");
      runOne(0, 64'h9000, '0, 0, lat);
      checkOutput("rstRecoverLat", lat, 3);
      drain(10);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
